// File: rtl/bottle_print_dispatch.sv
// bottle_print_dispatch: sends each accepted bottle trigger to one of NUM_ROADS
// print roads. Each road gets C consecutive bottles before the road pointer
// advances in forward-wrap or ping-pong order. The block also drives a
// fixed-width one-hot print strobe, counts bottles and keeps a sticky overrun flag.
module bottle_print_dispatch #(
  parameter int NUM_ROADS = 8,
  parameter int PULSE_W   = 20,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_100,
  input  logic                 nRST,
  input  logic                 dianyan_en,
  input  logic                 b_p_clr,
  input  logic                 valid_edge_f1,
  input  logic [7:0]           b_p_road_num,
  input  logic [7:0]           b_p_cycle_num,
  input  logic                 b_p_mode,
  output logic [NUM_ROADS-1:0] print_pulse,
  output logic [7:0]           print_road,
  output logic                 print_busy,
  output logic [CNT_W-1:0]     bottle_cnt,
  output logic                 overrun
);

  localparam logic [7:0]  MAX_ROADS  = 8'(NUM_ROADS);
  localparam logic [15:0] LAST_WIDTH = 16'(PULSE_W - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PULSE
  } state_t;

  state_t state, state_nxt;

  logic                 valid_d;
  logic                 rise;
  logic                 accept;

  logic [15:0]          width_cnt, width_cnt_nxt;
  logic [7:0]           road_ptr, road_ptr_nxt;
  logic [7:0]           cycle_cnt, cycle_cnt_nxt;
  logic                 dir_up, dir_up_nxt;

  logic [NUM_ROADS-1:0] print_pulse_nxt;
  logic [7:0]           print_road_nxt;
  logic [CNT_W-1:0]     bottle_cnt_nxt;
  logic                 overrun_nxt;

  logic [7:0]           n_eff;
  logic [7:0]           c_eff;
  logic [7:0]           sel_road;
  logic [7:0]           sel_cycle;
  logic                 sel_dir_up;
  logic [8:0]           cycle_inc;
  logic [7:0]           adv_road;
  logic                 adv_dir_up;

  assign rise       = valid_edge_f1 & ~valid_d;
  assign accept     = rise & dianyan_en & ~b_p_clr;
  assign print_busy = |print_pulse;

  // Clamp the run-time road and cycle counts into their usable ranges
  always_comb begin
    n_eff = b_p_road_num;
    if (b_p_road_num == 8'd0) begin
      n_eff = 8'd1;
    end else if (b_p_road_num > MAX_ROADS) begin
      n_eff = MAX_ROADS;
    end
    c_eff = (b_p_cycle_num == 8'd0) ? 8'd1 : b_p_cycle_num;
  end

  // Pick the road for a dispatch now; a pointer stranded outside a shrunken range restarts at road 0 going up
  always_comb begin
    sel_road   = road_ptr;
    sel_cycle  = cycle_cnt;
    sel_dir_up = dir_up;
    if (road_ptr >= n_eff) begin
      sel_road   = 8'd0;
      sel_cycle  = 8'd0;
      sel_dir_up = 1'b1;
    end
    cycle_inc = {1'b0, sel_cycle} + 9'd1;
  end

  // Work out which road follows the selected one in the current mode
  always_comb begin
    adv_road   = sel_road;
    adv_dir_up = sel_dir_up;
    if (!b_p_mode) begin
      adv_road = (sel_road == n_eff - 8'd1) ? 8'd0 : sel_road + 8'd1;
    end else if (n_eff == 8'd1) begin
      adv_road = 8'd0;
    end else if (sel_dir_up) begin
      if (sel_road == n_eff - 8'd1) begin
        adv_dir_up = 1'b0;
        adv_road   = n_eff - 8'd2;
      end else begin
        adv_road = sel_road + 8'd1;
      end
    end else begin
      if (sel_road == 8'd0) begin
        adv_dir_up = 1'b1;
        adv_road   = 8'd1;
      end else begin
        adv_road = sel_road - 8'd1;
      end
    end
  end

  // Next-state logic: clear wins over everything, otherwise dispatch from idle or time the running pulse
  always_comb begin
    state_nxt       = state;
    width_cnt_nxt   = width_cnt;
    road_ptr_nxt    = road_ptr;
    cycle_cnt_nxt   = cycle_cnt;
    dir_up_nxt      = dir_up;
    print_pulse_nxt = print_pulse;
    print_road_nxt  = print_road;
    bottle_cnt_nxt  = bottle_cnt;
    overrun_nxt     = overrun;

    if (b_p_clr) begin
      state_nxt       = ST_IDLE;
      width_cnt_nxt   = 16'd0;
      road_ptr_nxt    = 8'd0;
      cycle_cnt_nxt   = 8'd0;
      dir_up_nxt      = 1'b1;
      print_pulse_nxt = '0;
      bottle_cnt_nxt  = '0;
      overrun_nxt     = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_nxt       = ST_PULSE;
            width_cnt_nxt   = 16'd0;
            print_pulse_nxt = NUM_ROADS'(1) << sel_road;
            print_road_nxt  = sel_road;
            bottle_cnt_nxt  = bottle_cnt + CNT_W'(1);
            if (cycle_inc < {1'b0, c_eff}) begin
              cycle_cnt_nxt = cycle_inc[7:0];
              road_ptr_nxt  = sel_road;
              dir_up_nxt    = sel_dir_up;
            end else begin
              cycle_cnt_nxt = 8'd0;
              road_ptr_nxt  = adv_road;
              dir_up_nxt    = adv_dir_up;
            end
          end
        end
        ST_PULSE: begin
          if (width_cnt == LAST_WIDTH) begin
            state_nxt       = ST_IDLE;
            width_cnt_nxt   = 16'd0;
            print_pulse_nxt = '0;
          end else begin
            width_cnt_nxt = width_cnt + 16'd1;
          end
          if (accept) begin
            overrun_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt       = ST_IDLE;
          print_pulse_nxt = '0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; the trigger sample updates every cycle
  always_ff @(posedge clk_100) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      valid_d     <= 1'b0;
      width_cnt   <= 16'd0;
      road_ptr    <= 8'd0;
      cycle_cnt   <= 8'd0;
      dir_up      <= 1'b1;
      print_pulse <= '0;
      print_road  <= 8'd0;
      bottle_cnt  <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      valid_d     <= valid_edge_f1;
      width_cnt   <= width_cnt_nxt;
      road_ptr    <= road_ptr_nxt;
      cycle_cnt   <= cycle_cnt_nxt;
      dir_up      <= dir_up_nxt;
      print_pulse <= print_pulse_nxt;
      print_road  <= print_road_nxt;
      bottle_cnt  <= bottle_cnt_nxt;
      overrun     <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_bottle_print_dispatch.sv
// Testbench for bottle_print_dispatch: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural model.
module tb_bottle_print_dispatch;

  localparam int NUM_ROADS = 8;
  localparam int PULSE_W   = 20;
  localparam int CNT_W     = 16;

  logic                 clk_100 = 1'b0;
  logic                 nRST;
  logic                 dianyan_en;
  logic                 b_p_clr;
  logic                 valid_edge_f1;
  logic [7:0]           b_p_road_num;
  logic [7:0]           b_p_cycle_num;
  logic                 b_p_mode;
  logic [NUM_ROADS-1:0] print_pulse;
  logic [7:0]           print_road;
  logic                 print_busy;
  logic [CNT_W-1:0]     bottle_cnt;
  logic                 overrun;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  int               m_ptr  = 0;
  int               m_cyc  = 0;
  int               m_left = 0;
  int               m_road = 0;
  bit               m_up   = 1'b1;
  bit               m_ovr  = 1'b0;
  bit               m_prev = 1'b0;
  logic [CNT_W-1:0] m_cnt  = '0;

  int dut_roads[$];
  int exp_q[$];
  bit seen_busy = 1'b0;

  bottle_print_dispatch #(
    .NUM_ROADS(NUM_ROADS),
    .PULSE_W  (PULSE_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_100      (clk_100),
    .nRST         (nRST),
    .dianyan_en   (dianyan_en),
    .b_p_clr      (b_p_clr),
    .valid_edge_f1(valid_edge_f1),
    .b_p_road_num (b_p_road_num),
    .b_p_cycle_num(b_p_cycle_num),
    .b_p_mode     (b_p_mode),
    .print_pulse  (print_pulse),
    .print_road   (print_road),
    .print_busy   (print_busy),
    .bottle_cnt   (bottle_cnt),
    .overrun      (overrun)
  );

  // 100 MHz clock
  always #5 clk_100 = ~clk_100;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the model, computed from the dispatch rules
  task automatic modelStep();
    bit rise;
    int neff;
    int ceff;
    if (!nRST) begin
      m_ptr = 0; m_cyc = 0; m_left = 0; m_road = 0;
      m_up = 1'b1; m_ovr = 1'b0; m_prev = 1'b0; m_cnt = '0;
      return;
    end
    rise   = valid_edge_f1 && !m_prev;
    m_prev = valid_edge_f1;
    if (b_p_clr) begin
      m_ptr = 0; m_cyc = 0; m_up = 1'b1; m_cnt = '0; m_ovr = 1'b0; m_left = 0;
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (rise && dianyan_en) m_ovr = 1'b1;
    end else if (rise && dianyan_en) begin
      neff = (b_p_road_num == 0) ? 1 : ((b_p_road_num > NUM_ROADS) ? NUM_ROADS : int'(b_p_road_num));
      ceff = (b_p_cycle_num == 0) ? 1 : int'(b_p_cycle_num);
      if (m_ptr >= neff) begin
        m_ptr = 0; m_cyc = 0; m_up = 1'b1;
      end
      m_road = m_ptr;
      m_left = PULSE_W;
      m_cnt  = m_cnt + 1'b1;
      if (m_cyc + 1 < ceff) begin
        m_cyc++;
      end else begin
        m_cyc = 0;
        if (!b_p_mode) begin
          m_ptr = (m_road + 1) % neff;
        end else if (neff == 1) begin
          m_ptr = 0;
        end else if (m_up) begin
          if (m_road == neff - 1) begin m_up = 1'b0; m_ptr = neff - 2; end
          else m_ptr = m_road + 1;
        end else begin
          if (m_road == 0) begin m_up = 1'b1; m_ptr = 1; end
          else m_ptr = m_road - 1;
        end
      end
    end
  endtask

  // Drive one cycle, step the model, then compare every output just after the edge
  task automatic applyStimulus(input logic v);
    logic [7:0] exp_pulse;
    valid_edge_f1 = v;
    @(posedge clk_100);
    modelStep();
    #1;
    exp_pulse = (m_left > 0) ? (8'd1 << m_road) : 8'd0;
    checkOutput("pulse", print_pulse, exp_pulse);
    checkOutput("road", print_road, m_road);
    checkOutput("busy", print_busy, m_left > 0);
    checkOutput("cnt", bottle_cnt, m_cnt);
    checkOutput("ovr", overrun, m_ovr);
    if (print_pulse != 0 && !seen_busy) dut_roads.push_back(int'(print_road));
    seen_busy = (print_pulse != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic trig(input int gap);
    applyStimulus(1'b1);
    idle(gap);
  endtask

  task automatic clearPulse();
    b_p_clr = 1'b1;
    applyStimulus(1'b0);
    b_p_clr = 1'b0;
    dut_roads.delete();
  endtask

  // Compare the recorded DUT dispatch roads with the expected list
  task automatic checkRoads(input string tag);
    checkOutput({tag, "_len"}, dut_roads.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dut_roads.size(); i++)
      checkOutput($sformatf("%s_%0d", tag, i), dut_roads[i], exp_q[i]);
    dut_roads.delete();
  endtask

  initial begin
    nRST = 1'b0; dianyan_en = 1'b1; b_p_clr = 1'b0; valid_edge_f1 = 1'b0;
    b_p_road_num = 8'd6; b_p_cycle_num = 8'd1; b_p_mode = 1'b0;
    idle(3);
    checkOutput("rst_pulse", print_pulse, 0);
    checkOutput("rst_road", print_road, 0);
    checkOutput("rst_busy", print_busy, 0);
    checkOutput("rst_cnt", bottle_cnt, 0);
    checkOutput("rst_ovr", overrun, 0);
    nRST = 1'b1;
    idle(2);

    $display("[TB] forward wrap, N=6 C=1");
    for (int i = 0; i < 8; i++) trig(20);
    exp_q = '{0, 1, 2, 3, 4, 5, 0, 1};
    checkRoads("t1_roads");
    checkOutput("t1_cnt", bottle_cnt, 8);
    checkOutput("t1_ovr", overrun, 0);

    $display("[TB] ping-pong, N=3 C=2");
    clearPulse();
    b_p_road_num = 8'd3; b_p_cycle_num = 8'd2; b_p_mode = 1'b1;
    for (int i = 0; i < 10; i++) trig(20);
    exp_q = '{0, 0, 1, 1, 2, 2, 1, 1, 0, 0};
    checkRoads("t2_roads");

    $display("[TB] overrun and held trigger");
    clearPulse();
    b_p_road_num = 8'd6; b_p_cycle_num = 8'd1; b_p_mode = 1'b0;
    trig(4);
    trig(1);
    checkOutput("t3_ovr", overrun, 1);
    checkOutput("t3_cnt", bottle_cnt, 1);
    idle(20);
    trig(20);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1);
    idle(5);
    exp_q = '{0, 1, 2};
    checkRoads("t3_roads");
    checkOutput("t3_cnt_end", bottle_cnt, 3);

    $display("[TB] enable gating");
    clearPulse();
    trig(20);
    dianyan_en = 1'b0;
    idle(2); applyStimulus(1'b1); idle(2);
    dianyan_en = 1'b1;
    idle(3);
    checkOutput("t4_ovr", overrun, 0);
    checkOutput("t4_cnt", bottle_cnt, 1);
    trig(20);
    exp_q = '{0, 1};
    checkRoads("t4_roads");

    $display("[TB] clear with trigger, clamping");
    clearPulse();
    trig(20); trig(20);
    trig(5);
    b_p_clr = 1'b1; applyStimulus(1'b1); b_p_clr = 1'b0;
    idle(5);
    checkOutput("t5_busy", print_busy, 0);
    checkOutput("t5_cnt", bottle_cnt, 0);
    trig(20);
    exp_q = '{0, 1, 2, 0};
    checkRoads("t5_roads");
    clearPulse();
    b_p_road_num = 8'd0;
    for (int i = 0; i < 3; i++) trig(20);
    exp_q = '{0, 0, 0};
    checkRoads("t5_n0");
    clearPulse();
    b_p_road_num = 8'd20;
    for (int i = 0; i < 10; i++) trig(20);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    checkRoads("t5_n20");

    $display("[TB] reset mid-pulse, reconfiguration");
    clearPulse();
    b_p_road_num = 8'd6;
    trig(20);
    trig(5);
    nRST = 1'b0; applyStimulus(1'b0); nRST = 1'b1;
    checkOutput("t6_rst_pulse", print_pulse, 0);
    checkOutput("t6_rst_cnt", bottle_cnt, 0);
    idle(2);
    trig(20);
    exp_q = '{0, 1, 0};
    checkRoads("t6_rst_roads");
    clearPulse();
    for (int i = 0; i < 4; i++) trig(20);
    b_p_road_num = 8'd3;
    trig(20);
    trig(20);
    exp_q = '{0, 1, 2, 3, 0, 1};
    checkRoads("t6_shrink");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        b_p_road_num  = 8'($urandom_range(0, 12));
        b_p_cycle_num = 8'($urandom_range(0, 3));
        b_p_mode      = 1'($urandom_range(0, 1));
      end
      dianyan_en = ($urandom_range(0, 15) != 0);
      b_p_clr    = ($urandom_range(0, 149) == 0);
      nRST       = ($urandom_range(0, 499) != 0);
      applyStimulus($urandom_range(0, 9) == 0);
    end
    nRST = 1'b1; b_p_clr = 1'b0; dianyan_en = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bottle_print_dispatch.md
Name: bottle_print_dispatch

Overview:
- Parametrised successor to the single-channel bottle-print trigger block.
- Each accepted bottle trigger (valid_edge_f1) is dispatched to one of up to NUM_ROADS print roads.
- Each road receives b_p_cycle_num consecutive bottles before the block advances to the next road.
- Adds run-time selectable forward-wrap or ping-pong road order, a fixed-width per-road print pulse, a bottle counter and sticky overrun detection; sits between bottle detection and the print-head drivers.

Parameters:
NUM_ROADS, 8, number of physical print roads; legal range 1..255.
PULSE_W, 20, print pulse width in clk_100 cycles; legal range 1..65535.
CNT_W, 16, bottle_cnt width in bits.

Ports:
clk_100  in  1  system clock (100 MHz); all logic on rising edge.
nRST  in  1  reset; synchronous, active-low.
dianyan_en  in  1  dispatch enable; triggers are ignored while low.
b_p_clr  in  1  synchronous clear of counters, road pointer and overrun.
valid_edge_f1  in  1  bottle trigger; level or pulse, rising edge detected internally.
b_p_road_num  in  8  active road count N.
b_p_cycle_num  in  8  bottles per road C.
b_p_mode  in  1  0 = forward wrap; 1 = ping-pong.
print_pulse  out  NUM_ROADS  one-hot print strobe.
print_road  out  8  road index of the most recent dispatch.
print_busy  out  1  high while any print_pulse bit is high.
bottle_cnt  out  CNT_W  accepted-trigger count; wraps modulo 2^CNT_W.
overrun  out  1  sticky; a trigger was dropped because print_busy was high.

Behaviour:
- Reset (nRST low at a clock edge) clears all of the following. Outputs: print_pulse, print_road, print_busy, bottle_cnt, overrun all 0. Internal state: FSM = IDLE, road pointer = 0, cycle counter = 0, direction = up, edge-detect register = 0.
- Edge detect: rise = valid_edge_f1 AND NOT previous-cycle sample. The edge-detect register updates every cycle regardless of dianyan_en. A held-high trigger counts once.
- Effective configuration: Neff = 1 if N = 0, NUM_ROADS if N > NUM_ROADS, else N. Ceff = 1 if C = 0, else C.
- Accept: rise AND dianyan_en AND NOT b_p_clr.
  - FSM in IDLE: dispatch.
  - FSM in PULSE: trigger is dropped, overrun is set to 1, counters are unchanged.
- Dispatch at edge t:
  - Road r = current pointer; if pointer >= Neff, r = 0, cycle counter is treated as 0 and direction is forced up.
  - From t+1: print_pulse = one-hot(r) for exactly PULSE_W cycles; print_road = r; print_busy = 1; bottle_cnt + 1.
  - If cycle counter + 1 < Ceff: cycle counter increments and the pointer holds.
  - Otherwise: cycle counter = 0 and the pointer advances.
- Advance, mode 0: pointer = (r + 1) mod Neff.
- Advance, mode 1 (ping-pong):
  - Going up at r = Neff-1: direction flips down, next = Neff-2.
  - Going down at r = 0: direction flips up, next = 1.
  - Otherwise next = r ± 1.
  - Neff = 1 gives a constant 0; Neff = 2 alternates 0,1,0,1.
- b_p_mode and configuration are sampled at each dispatch only; a change takes effect on the next advance.
- FSM:
  - IDLE -> PULSE on dispatch.
  - PULSE: width counter counts 0..PULSE_W-1, then -> IDLE. print_pulse clears on the cycle after the last pulse cycle.
  - A rise on the first IDLE cycle after PULSE is accepted.
- dianyan_en low: no new dispatch. An in-progress pulse completes. Pointer, cycle counter and bottle_cnt hold. Re-enabling resumes from the held pointer.
- b_p_clr high: pointer, cycle counter, bottle_cnt and overrun = 0; direction = up; FSM -> IDLE; print_pulse = 0 from the next cycle. Clear wins over a simultaneous trigger; the edge-detect register still updates.
- nRST mid-pulse: pulse aborts on the reset edge and all state is reset.

Test Plan:
1. Default parameters; N=6, C=1, mode 0; one trigger every 210 ns for 8 bottles -> print_road 0,1,2,3,4,5,0,1; print_pulse one-hot, 20 cycles each, first at trigger edge +1; bottle_cnt = 8; overrun = 0.
2. N=3, C=2, mode 1; 10 triggers -> roads 0,0,1,1,2,2,1,1,0,0.
3. Overrun and held trigger:
   - Trigger 5 cycles into a 20-cycle pulse -> dropped; overrun = 1; bottle_cnt unchanged; next road unchanged after the pulse ends.
   - valid_edge_f1 held high 100 cycles -> exactly one dispatch.
4. Enable gating: dianyan_en low for 5 cycles covering a trigger -> no dispatch and no overrun. Next trigger after re-enable -> uses the held road.
5. Clear and clamping:
   - b_p_clr pulse coincident with a trigger mid-sequence -> no dispatch; pulse ends; bottle_cnt = 0; next trigger -> road 0.
   - N=0 -> all dispatches to road 0.
   - N=20 with NUM_ROADS=8 -> roads wrap after road 7.
6. Reset and mid-run reconfiguration:
   - nRST low mid-pulse -> all outputs 0 on the next edge; next trigger -> road 0.
   - Pointer at 4, then N changed to 3 -> next dispatch to road 0.
